key_load_ctrl: RTL and testbench
================================

KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

Interface
REQ-001 The block SHALL have parameter KEY_X_W, default 33, meaning the width of the XOR key-gate bus (X_1..X_33 of the locked c432).
REQ-002 The block SHALL have parameter KEY_P_W, default 4, meaning the width of the mux key bus (p1..p4).
REQ-003 clk  input  1  the single clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  single-cycle pulse that begins a key load.
REQ-006 clear  input  1  synchronous zeroize and abort.
REQ-007 key_bit  input  1  serial key data.
REQ-008 key_bit_valid  input  1  key_bit is valid this cycle.
REQ-009 key_bit_ready  output  1  the block accepts key_bit this cycle.
REQ-010 key_x  output  KEY_X_W  drives X_1..X_33; bit i drives X_(i+1).
REQ-011 key_p  output  KEY_P_W  drives p1..p4; bit i drives p(i+1).
REQ-012 key_loaded  output  1  key_x and key_p hold a completely committed key.
REQ-013 busy  output  1  a load is in progress.
REQ-014 err  output  1  parity failure flag.

Function
REQ-015 The block SHALL implement the states IDLE, LOAD, DONE and ERR, with ERR present only under REQ-029.
- Transitions: IDLE/DONE/ERR --start--> LOAD; LOAD --last bit accepted--> DONE (or ERR).
REQ-016 A bit SHALL transfer only on a cycle with key_bit_valid=1 and key_bit_ready=1; key_bit_ready SHALL be 1 exactly while in LOAD.
REQ-017 Bits SHALL arrive LSB-first: transfer k (k=0..32) goes to key_x[k], and transfer 33+j (j=0..3) goes to key_p[j].
REQ-018 A 6-bit counter SHALL count accepted bits from 0; the final transfer is KEY_X_W+KEY_P_W-1 (36).
REQ-019 Bits SHALL accumulate in an internal shadow register; key_x and key_p SHALL update only at commit, as one atomic write, in the cycle after the final transfer, together with key_loaded=1.
REQ-020 Latency: start at cycle 0 puts the block in LOAD with key_bit_ready=1 at cycle 1. A continuous valid stream gives key_loaded=1 at cycle 38.
REQ-021 busy SHALL be 1 exactly while in LOAD.
REQ-022 Any gap cycles (valid=0) SHALL stall the load indefinitely with no timeout.
REQ-023 start while in LOAD SHALL be ignored.
REQ-024 start in DONE SHALL drop key_loaded to 0 the next cycle; key_x and key_p SHALL keep the previous key until the new commit.
REQ-025 clear SHALL, on the next edge, zero key_x, key_p, the shadow register and the counter, set key_loaded=0 and err=0, and go to IDLE.
REQ-026 clear SHALL take priority over start and over a simultaneous final-bit transfer; in that case nothing is committed.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and zero the counter and shadow register; key_x, key_p, key_loaded, busy, err and key_bit_ready SHALL all be 0.
REQ-028 Reset asserted mid-LOAD SHALL discard the partial key; the outputs stay 0 after release until a full load completes.

Configuration
REQ-029 With macro KEY_PARITY_CHK_EN defined, the load SHALL be 38 transfers.
- Transfer 37 is an even-parity bit over the preceding 37 bits.
- On mismatch: go to ERR, set err=1, leave key_x/key_p unchanged, keep key_loaded=0.
- ERR is left only by start (err clears on entering LOAD) or by clear.
- On match: commit as in REQ-019; key_loaded=1 at cycle 39 with continuous valid.
REQ-030 Without KEY_PARITY_CHK_EN, the load SHALL be 37 transfers, err SHALL be tied 0, and no ERR state SHALL exist.

Structure
REQ-031 A shared package key_lock_pkg SHALL hold: the state enum, KEY_X_W=33, KEY_P_W=4, KEY_TOT_W=37, and the counter width 6.
REQ-032 One sub-module, key_shift_reg, SHALL hold the serial-in shadow register with a load-enable and a synchronous clear. The FSM and counter SHALL stay in key_load_ctrl.

Verification
REQ-033 Without the macro: start, then 37 consecutive bits where key_x = 33'h0_0000_0001 and key_p = 4'b1000 -> key_loaded=1 at cycle 38, key_x=1, key_p=8, busy=0.
REQ-034 The same load with valid low for 5 cycles after bit 10 -> key_loaded=1 at cycle 43, and the outputs match the stream.
REQ-035 Load A (all 1s) to DONE, then start and send 20 bits of B -> key_x stays all-1s with key_loaded=0; after B completes, key_x = B.
REQ-036 clear on the same cycle as the 37th transfer -> IDLE, key_x=0, key_p=0, key_loaded=0.
REQ-037 rst_n low at bit 15, release, then idle for 10 cycles -> all outputs 0 and key_bit_ready=0.
REQ-038 With KEY_PARITY_CHK_EN: a 37-bit stream of all 1s followed by parity bit 0 -> err=1 and key_x unchanged. Repeating with parity bit 1 -> key_loaded=1 at cycle 39 and err=0.

Source files
------------

// File: rtl/key_lock_pkg.sv
// rtl/key_lock_pkg.sv - shared types and widths for the key loader (KEY_PARITY_CHK_EN adds the ERR state)
package key_lock_pkg;

   localparam int KEY_X_W   = 33;
   localparam int KEY_P_W   = 4;
   localparam int KEY_TOT_W = KEY_X_W + KEY_P_W;
   localparam int CNT_W     = 6;

`ifdef KEY_PARITY_CHK_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;
`endif

endpackage

// File: rtl/key_shift_reg.sv
// rtl/key_shift_reg.sv - serial-in shadow register, LSB-first, with load-enable and synchronous clear
module key_shift_reg #(
   parameter int W = 37
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic         din,
   output logic [W-1:0] q
);

   // New bits enter at the MSB so the first bit lands in q[0] after W shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= {din, q[W-1:1]};
      end
   end

endmodule

// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - serial key loader for the locked c432; KEY_PARITY_CHK_EN adds a trailing even-parity bit
module key_load_ctrl #(
   parameter int KEY_X_W = key_lock_pkg::KEY_X_W,
   parameter int KEY_P_W = key_lock_pkg::KEY_P_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               clear,
   input  logic               key_bit,
   input  logic               key_bit_valid,
   output logic               key_bit_ready,
   output logic [KEY_X_W-1:0] key_x,
   output logic [KEY_P_W-1:0] key_p,
   output logic               key_loaded,
   output logic               busy,
   output logic               err
);

   import key_lock_pkg::*;

   localparam int TOT_W = KEY_X_W + KEY_P_W;
`ifdef KEY_PARITY_CHK_EN
   localparam int LOAD_LEN = TOT_W + 1;
`else
   localparam int LOAD_LEN = TOT_W;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_LEN - 1);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [TOT_W-1:0]   shadow_q;
   logic [TOT_W-1:0]   key_q;
   logic               loaded_q;
   logic               busy_q;
   logic               xfer;
   logic               shift_en;

   assign xfer = (state_q == ST_LOAD) && key_bit_valid;

`ifdef KEY_PARITY_CHK_EN
   logic err_q;
   logic parity_ok;
   // The parity bit itself is never shifted in; the shadow already holds the full key.
   assign shift_en  = xfer && (cnt_q < CNT_W'(TOT_W));
   assign parity_ok = ~(^{shadow_q, key_bit});
   assign err       = err_q;
`else
   logic [TOT_W-1:0] shadow_full;
   // The last key bit is merged on the fly so the commit lands in the cycle after it.
   assign shift_en    = xfer;
   assign shadow_full = {key_bit, shadow_q[TOT_W-1:1]};
   assign err         = 1'b0;
`endif

   key_shift_reg #(
      .W (TOT_W)
   ) u_shadow (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .en    (shift_en),
      .din   (key_bit),
      .q     (shadow_q)
   );

   // Load sequencing, bit counting and atomic commit of the visible key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         key_q    <= '0;
         loaded_q <= 1'b0;
         busy_q   <= 1'b0;
`ifdef KEY_PARITY_CHK_EN
         err_q    <= 1'b0;
`endif
      end else if (clear) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         key_q    <= '0;
         loaded_q <= 1'b0;
         busy_q   <= 1'b0;
`ifdef KEY_PARITY_CHK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (xfer) begin
                  if (cnt_q == LAST_CNT) begin
                     cnt_q  <= '0;
                     busy_q <= 1'b0;
`ifdef KEY_PARITY_CHK_EN
                     if (parity_ok) begin
                        state_q  <= ST_DONE;
                        key_q    <= shadow_q;
                        loaded_q <= 1'b1;
                     end else begin
                        state_q  <= ST_ERR;
                        err_q    <= 1'b1;
                     end
`else
                     state_q  <= ST_DONE;
                     key_q    <= shadow_full;
                     loaded_q <= 1'b1;
`endif
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               if (start) begin
                  state_q  <= ST_LOAD;
                  cnt_q    <= '0;
                  loaded_q <= 1'b0;
                  busy_q   <= 1'b1;
`ifdef KEY_PARITY_CHK_EN
                  err_q    <= 1'b0;
`endif
               end
            end
         endcase
      end
   end

   assign key_x         = key_q[KEY_X_W-1:0];
   assign key_p         = key_q[TOT_W-1:KEY_X_W];
   assign key_loaded    = loaded_q;
   assign busy          = busy_q;
   assign key_bit_ready = busy_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb/tb_key_load_ctrl.sv - self-checking bench for key_load_ctrl
module tb_key_load_ctrl;

   localparam int XW = 33;
   localparam int PW = 4;
`ifdef KEY_PARITY_CHK_EN
   localparam int LEN = 38;
`else
   localparam int LEN = 37;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          clear;
   logic          key_bit;
   logic          key_bit_valid;
   logic          key_bit_ready;
   logic [XW-1:0] key_x;
   logic [PW-1:0] key_p;
   logic          key_loaded;
   logic          busy;
   logic          err;

   int checks = 0;
   int errors = 0;

   key_load_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .clear         (clear),
      .key_bit       (key_bit),
      .key_bit_valid (key_bit_valid),
      .key_bit_ready (key_bit_ready),
      .key_x         (key_x),
      .key_p         (key_p),
      .key_loaded    (key_loaded),
      .busy          (busy),
      .err           (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serial stream as the spec orders it: x bits, then p bits, then (optionally) even parity.
   function automatic logic [37:0] make_stream(input logic [XW-1:0] x, input logic [PW-1:0] p, input logic flip);
      logic [37:0] s;
      int ones;
      s = '0;
      ones = 0;
      for (int i = 0; i < XW; i++) begin
         s[i] = x[i];
         if (x[i]) ones++;
      end
      for (int j = 0; j < PW; j++) begin
         s[XW + j] = p[j];
         if (p[j]) ones++;
      end
      s[37] = ((ones % 2) == 1) ^ flip;
      return s;
   endfunction

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_range(input logic [37:0] s, input int from, input int upto, input int gap_at, input int gap_len);
      for (int i = from; i <= upto; i++) begin
         key_bit = s[i];
         key_bit_valid = 1'b1;
         tick();
         if (i == gap_at) begin
            key_bit_valid = 1'b0;
            for (int g = 0; g < gap_len; g++) begin
               key_bit = 1'($urandom_range(0, 1));
               tick();
            end
         end
      end
      key_bit_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({key_x, key_p, key_loaded, busy, err, key_bit_ready} !== '0) begin
         errors++;
         $display("FAIL reset_asserted: got x=%h p=%h ld=%b busy=%b err=%b rdy=%b expected all 0", key_x, key_p, key_loaded, busy, err, key_bit_ready);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({key_x, key_p, key_loaded, busy, err, key_bit_ready} !== '0) begin
         errors++;
         $display("FAIL reset_released: got x=%h p=%h ld=%b busy=%b err=%b rdy=%b expected all 0", key_x, key_p, key_loaded, busy, err, key_bit_ready);
      end
   endtask

   task automatic test_basic();
      logic [37:0] s;
      s = make_stream(33'h0_0000_0001, 4'b1000, 1'b0);
      do_start();
      checks++;
      if (key_bit_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_cycle1: got rdy=%b busy=%b expected 1 1", key_bit_ready, busy);
      end
      send_range(s, 0, LEN - 2, -1, 0);
      checks++;
      if (key_loaded !== 1'b0 || key_x !== '0 || key_p !== '0) begin
         errors++;
         $display("FAIL basic_before_commit: got ld=%b x=%h p=%h expected 0 0 0", key_loaded, key_x, key_p);
      end
      send_range(s, LEN - 1, LEN - 1, -1, 0);
      checks++;
      if (key_loaded !== 1'b1 || key_x !== 33'h1 || key_p !== 4'h8 || busy !== 1'b0 || key_bit_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_commit: got ld=%b x=%h p=%h busy=%b rdy=%b expected 1 1 8 0 0", key_loaded, key_x, key_p, busy, key_bit_ready);
      end
   endtask

   task automatic test_gap();
      logic [37:0] s;
      int cyc;
      s = make_stream({1'($urandom), 32'($urandom)}, 4'($urandom), 1'b0);
      do_start();
      cyc = 1;
      send_range(s, 0, LEN - 2, 10, 5);
      cyc += (LEN - 1) + 5;
      checks++;
      if (key_loaded !== 1'b0) begin
         errors++;
         $display("FAIL gap_early_load: cycle %0d got ld=%b expected 0", cyc, key_loaded);
      end
      send_range(s, LEN - 1, LEN - 1, -1, 0);
      cyc++;
      checks++;
      if (key_loaded !== 1'b1 || key_x !== s[32:0] || key_p !== s[36:33]) begin
         errors++;
         $display("FAIL gap_commit: cycle %0d got ld=%b x=%h p=%h expected 1 %h %h", cyc, key_loaded, key_x, key_p, s[32:0], s[36:33]);
      end
   endtask

   task automatic test_reload();
      logic [37:0] a;
      logic [37:0] b;
      a = make_stream({XW{1'b1}}, {PW{1'b1}}, 1'b0);
      b = make_stream({1'($urandom), 32'($urandom)} & ~33'h1, 4'($urandom), 1'b0);
      do_start();
      send_range(a, 0, LEN - 1, -1, 0);
      checks++;
      if (key_loaded !== 1'b1 || key_x !== {XW{1'b1}}) begin
         errors++;
         $display("FAIL reload_a: got ld=%b x=%h expected 1 all-ones", key_loaded, key_x);
      end
      do_start();
      checks++;
      if (key_loaded !== 1'b0 || key_x !== {XW{1'b1}}) begin
         errors++;
         $display("FAIL reload_drop: got ld=%b x=%h expected 0 all-ones", key_loaded, key_x);
      end
      send_range(b, 0, 19, -1, 0);
      checks++;
      if (key_loaded !== 1'b0 || key_x !== {XW{1'b1}} || key_p !== {PW{1'b1}}) begin
         errors++;
         $display("FAIL reload_partial: got ld=%b x=%h p=%h expected 0 all-ones", key_loaded, key_x, key_p);
      end
      send_range(b, 20, LEN - 1, -1, 0);
      checks++;
      if (key_loaded !== 1'b1 || key_x !== b[32:0] || key_p !== b[36:33]) begin
         errors++;
         $display("FAIL reload_b: got ld=%b x=%h p=%h expected 1 %h %h", key_loaded, key_x, key_p, b[32:0], b[36:33]);
      end
   endtask

   task automatic test_start_ignored();
      logic [37:0] s;
      s = make_stream({1'($urandom), 32'($urandom)}, 4'($urandom), 1'b0);
      do_start();
      send_range(s, 0, 14, -1, 0);
      start = 1'b1;
      send_range(s, 15, 15, -1, 0);
      start = 1'b0;
      send_range(s, 16, LEN - 1, -1, 0);
      checks++;
      if (key_loaded !== 1'b1 || key_x !== s[32:0] || key_p !== s[36:33]) begin
         errors++;
         $display("FAIL start_in_load: got ld=%b x=%h p=%h expected 1 %h %h", key_loaded, key_x, key_p, s[32:0], s[36:33]);
      end
   endtask

   task automatic test_clear_final();
      logic [37:0] s;
      s = make_stream({1'($urandom), 32'($urandom)}, 4'($urandom), 1'b0);
      do_start();
      send_range(s, 0, LEN - 2, -1, 0);
      key_bit = s[LEN - 1];
      key_bit_valid = 1'b1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      key_bit_valid = 1'b0;
      checks++;
      if (key_x !== '0 || key_p !== '0 || key_loaded !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL clear_final: got x=%h p=%h ld=%b busy=%b err=%b expected all 0", key_x, key_p, key_loaded, busy, err);
      end
      start = 1'b1;
      clear = 1'b1;
      tick();
      start = 1'b0;
      clear = 1'b0;
      checks++;
      if (busy !== 1'b0 || key_bit_ready !== 1'b0) begin
         errors++;
         $display("FAIL clear_over_start: got busy=%b rdy=%b expected 0 0", busy, key_bit_ready);
      end
   endtask

   task automatic test_random();
      logic [37:0] s;
      int gap_at;
      int gap_len;
      for (int n = 0; n < 4; n++) begin
         s = make_stream({1'($urandom), 32'($urandom)}, 4'($urandom), 1'b0);
         gap_at = int'($urandom_range(0, LEN - 2));
         gap_len = int'($urandom_range(0, 4));
         do_start();
         send_range(s, 0, LEN - 2, gap_at, gap_len);
         checks++;
         if (key_loaded !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL random_%0d_pending: got ld=%b busy=%b expected 0 1", n, key_loaded, busy);
         end
         send_range(s, LEN - 1, LEN - 1, -1, 0);
         checks++;
         if (key_loaded !== 1'b1 || key_x !== s[32:0] || key_p !== s[36:33] || err !== 1'b0) begin
            errors++;
            $display("FAIL random_%0d_commit: got ld=%b x=%h p=%h err=%b expected 1 %h %h 0", n, key_loaded, key_x, key_p, err, s[32:0], s[36:33]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [37:0] s;
      s = make_stream({1'($urandom), 32'($urandom)}, 4'($urandom), 1'b0);
      do_start();
      send_range(s, 0, 14, -1, 0);
      key_bit = s[15];
      key_bit_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({key_x, key_p, key_loaded, busy, key_bit_ready} !== '0) begin
         errors++;
         $display("FAIL reset_mid_async: got x=%h p=%h ld=%b busy=%b rdy=%b expected all 0", key_x, key_p, key_loaded, busy, key_bit_ready);
      end
      key_bit_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      checks++;
      if ({key_x, key_p, key_loaded, busy, err, key_bit_ready} !== '0) begin
         errors++;
         $display("FAIL reset_mid_idle: got x=%h p=%h ld=%b busy=%b err=%b rdy=%b expected all 0", key_x, key_p, key_loaded, busy, err, key_bit_ready);
      end
   endtask

`ifdef KEY_PARITY_CHK_EN
   task automatic test_parity();
      logic [37:0] k;
      logic [37:0] bad;
      logic [37:0] good;
      k = make_stream({1'($urandom), 32'($urandom)}, 4'($urandom), 1'b0);
      bad = make_stream({XW{1'b1}}, {PW{1'b1}}, 1'b1);
      good = make_stream({XW{1'b1}}, {PW{1'b1}}, 1'b0);
      do_start();
      send_range(k, 0, LEN - 1, -1, 0);
      do_start();
      send_range(bad, 0, LEN - 1, -1, 0);
      checks++;
      if (err !== 1'b1 || key_loaded !== 1'b0 || key_x !== k[32:0] || key_p !== k[36:33] || busy !== 1'b0) begin
         errors++;
         $display("FAIL parity_bad: got err=%b ld=%b x=%h p=%h busy=%b expected 1 0 %h %h 0", err, key_loaded, key_x, key_p, busy, k[32:0], k[36:33]);
      end
      do_start();
      checks++;
      if (err !== 1'b0 || key_bit_ready !== 1'b1) begin
         errors++;
         $display("FAIL parity_restart: got err=%b rdy=%b expected 0 1", err, key_bit_ready);
      end
      send_range(good, 0, LEN - 2, -1, 0);
      checks++;
      if (key_loaded !== 1'b0) begin
         errors++;
         $display("FAIL parity_early: got ld=%b expected 0", key_loaded);
      end
      send_range(good, LEN - 1, LEN - 1, -1, 0);
      checks++;
      if (key_loaded !== 1'b1 || err !== 1'b0 || key_x !== {XW{1'b1}} || key_p !== {PW{1'b1}}) begin
         errors++;
         $display("FAIL parity_good: got ld=%b err=%b x=%h p=%h expected 1 0 all-ones", key_loaded, err, key_x, key_p);
      end
   endtask
`endif

   initial begin
      start = 1'b0;
      clear = 1'b0;
      key_bit = 1'b0;
      key_bit_valid = 1'b0;
      test_reset();
      test_basic();
      test_gap();
      test_reload();
      test_start_ignored();
      test_clear_final();
      test_random();
      test_reset_mid();
`ifdef KEY_PARITY_CHK_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
